// File: rtl/memory_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage_pkg                                                     |
// | Shared funct3 encodings, fault codes, FSM state type and helpers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_stage_pkg;

    localparam int c_TIMEOUT_DEFAULT = 16;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_FAULT_NONE     = 2'b00;
    localparam logic [1:0] c_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] c_FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [0:0] {
        c_IDLE = 1'b0,
        c_WAIT = 1'b1
    } state_t;

    // Stores only support B/H/W; loads additionally allow BU/HU.
    function automatic logic isIllegalF3(input logic isStore, input logic [2:0] funct3);
        if (isStore) begin
            return !(funct3 == c_F3_B || funct3 == c_F3_H || funct3 == c_F3_W);
        end
        return !(funct3 == c_F3_B || funct3 == c_F3_H || funct3 == c_F3_W ||
                 funct3 == c_F3_BU || funct3 == c_F3_HU);
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic w_mis;
        w_mis = 1'b0;
        case (funct3)
            c_F3_H, c_F3_HU: w_mis = addrLo[0];
            c_F3_W:          w_mis = (addrLo != 2'b00);
            default:         w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage_if                                                      |
// | Data-memory bus between the memory stage (master) and memory.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_stage_mem_load_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_load_ext                                                         |
// | Selects the loaded byte/halfword by address and extends it.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_load_ext
    import memory_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addrLo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addrLo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_loadData = i_rdata;
        case (i_funct3)
            c_F3_B:  o_loadData = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: o_loadData = {24'h000000, w_byte};
            c_F3_H:  o_loadData = {{16{w_half[15]}}, w_half};
            c_F3_HU: o_loadData = {16'h0000, w_half};
            default: o_loadData = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage                                                         |
// | Pipeline MEM stage: data-memory handshake, faults, MEM/WB register.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validM,
    input  logic [2:0]    strCtrlM,
    input  logic          RegWriteM,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    input  logic [31:0]   ALUoutM,
    input  logic [31:0]   r2M,
    input  logic [4:0]    rdM,
    memory_stage_if.master bus,
    output logic          stallM,
    output logic          validW,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic [31:0]   ALUoutW,
    output logic [31:0]   readDataW,
    output logic [4:0]    rdW,
    output logic [1:0]    faultW
);

    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    state_t               r_state;
    state_t               w_nextState;
    logic [c_CNT_W-1:0]   r_count;

    logic        w_memOp;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_access;
    logic        w_req;
    logic        w_stall;
    logic        w_timeout;
    logic [1:0]  w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;
    logic [31:0] w_readData;

    assign w_memOp      = validM & (MemWriteM | MemtoRegM);
    assign w_illegal    = w_memOp & isIllegalF3(MemWriteM, strCtrlM);
    assign w_misaligned = w_memOp & ~w_illegal & isMisaligned(strCtrlM, ALUoutM[1:0]);
    assign w_access     = w_memOp & ~w_illegal & ~w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == c_WAIT && w_nextState == c_WAIT) begin
                r_count <= r_count + c_CNT_W'(1);
            end else begin
                r_count <= '0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (!bus.dmem_ack) begin
                        w_stall     = 1'b1;
                        w_nextState = c_WAIT;
                    end
                end
            end
            c_WAIT: begin
                if (bus.dmem_ack) begin
                    w_req       = 1'b1;
                    w_nextState = c_IDLE;
                end else if (r_count == c_CNT_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_nextState = c_IDLE;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
        // Reset must silence the bus even mid-access, before any clock edge.
        if (rst) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r2M;
        case (strCtrlM[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUoutM[1:0];
                w_wdata = {4{r2M[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ALUoutM[1:0];
                w_wdata = {2{r2M[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r2M;
            end
        endcase
    end

    assign bus.dmem_req   = w_req;
    assign bus.dmem_we    = w_req & MemWriteM;
    assign bus.dmem_addr  = {ALUoutM[31:2], 2'b00};
    assign bus.dmem_be    = w_req ? w_be : 4'b0000;
    assign bus.dmem_wdata = w_wdata;
    assign stallM         = w_stall;

    mem_load_ext u_loadExt (
        .i_rdata    (bus.dmem_rdata),
        .i_addrLo   (ALUoutM[1:0]),
        .i_funct3   (strCtrlM),
        .o_loadData (w_loadData)
    );

    always_comb begin
        w_fault = c_FAULT_NONE;
        if (w_illegal) begin
            w_fault = c_FAULT_ILLEGAL;
        end else if (w_misaligned) begin
            w_fault = c_FAULT_MISALIGN;
        end else if (w_timeout) begin
            w_fault = c_FAULT_TIMEOUT;
        end
    end

    assign w_readData = (w_access & ~MemWriteM & ~w_timeout) ? w_loadData : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= 32'h0;
            readDataW <= 32'h0;
            rdW       <= 5'd0;
            faultW    <= c_FAULT_NONE;
        end else if (w_stall) begin
            validW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= 32'h0;
            readDataW <= 32'h0;
            rdW       <= 5'd0;
            faultW    <= c_FAULT_NONE;
        end else begin
            validW    <= validM;
            RegWriteW <= validM & RegWriteM & ~(w_memOp & MemWriteM) & (w_fault == c_FAULT_NONE);
            MemtoRegW <= validM & MemtoRegM;
            ALUoutW   <= ALUoutM;
            readDataW <= w_readData;
            rdW       <= rdM;
            faultW    <= w_fault;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_stage                                                      |
// | Directed plus random checks of memory_stage against a behaviour model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_memory_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic [31:0] ALUoutM, r2M;
    logic [4:0]  rdM;
    logic        stallM, validW, RegWriteW, MemtoRegW;
    logic [31:0] ALUoutW, readDataW;
    logic [4:0]  rdW;
    logic [1:0]  faultW;

    int nChecks = 0;
    int nFail   = 0;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .validM    (validM),
        .strCtrlM  (strCtrlM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .MemtoRegM (MemtoRegM),
        .ALUoutM   (ALUoutM),
        .r2M       (r2M),
        .rdM       (rdM),
        .bus       (bus),
        .stallM    (stallM),
        .validW    (validW),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ALUoutW   (ALUoutW),
        .readDataW (readDataW),
        .rdW       (rdW),
        .faultW    (faultW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 1;
        endcase
    endfunction

    // One instruction in M, from its first cycle until it leaves to WB.
    // ackDelay: wait cycles before dmem_ack (0 = same cycle, -1 = never).
    task automatic runOp(input string nm, input logic v, input logic [2:0] f3,
                         input logic rw, input logic mw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input int ackDelay,
                         input logic [31:0] rdataIn);
        bit isMem, illegal, mis, access, ackNow, toNow, expStall, expReq, done;
        int sz, cyc, unitVal;
        logic [31:0] expRead, expBe, expWdata;
        logic [1:0]  expFault;

        isMem   = v && (mw || m2r);
        illegal = isMem && (mw ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7}));
        sz      = sizeOf(f3);
        mis     = isMem && !illegal && ((addr % sz) != 0);
        access  = isMem && !illegal && !mis;

        unitVal = int'((rdataIn >> (8 * addr[1:0])) & ((sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 1)));
        expRead = 32'(unitVal);
        if (f3 == 3'd0 && unitVal >= 128)   expRead = 32'(unitVal - 256);
        if (f3 == 3'd1 && unitVal >= 32768) expRead = 32'(unitVal - 65536);
        expBe    = (sz == 4) ? 32'hF : (((32'd1 << sz) - 1) << addr[1:0]);
        expWdata = (sz == 1) ? (data & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (data & 32'hFFFF) * 32'h00010001 : data;

        validM = v; strCtrlM = f3; RegWriteM = rw; MemWriteM = mw; MemtoRegM = m2r;
        ALUoutM = addr; r2M = data; rdM = rd;
        cyc = 0; done = 0;
        while (!done) begin
            ackNow   = access && ackDelay >= 0 && cyc == ackDelay;
            toNow    = access && !ackNow && cyc == TIMEOUT;
            expReq   = access && !toNow;
            expStall = access && !ackNow && !toNow;
            bus.dmem_ack   = ackNow;
            bus.dmem_rdata = ackNow ? rdataIn : $urandom();
            @(negedge clk);
            check({nm, ".req"},   bus.dmem_req, expReq);
            check({nm, ".stall"}, stallM, expStall);
            if (expReq) begin
                check({nm, ".addr"}, bus.dmem_addr, addr & 32'hFFFFFFFC);
                check({nm, ".we"},   bus.dmem_we, mw);
                if (mw) begin
                    check({nm, ".be"},    bus.dmem_be, expBe);
                    check({nm, ".wdata"}, bus.dmem_wdata, expWdata);
                end
            end
            @(posedge clk); #1;
            if (expStall) begin
                check({nm, ".bubbleValid"}, validW, 0);
                check({nm, ".bubbleRegW"},  RegWriteW, 0);
                check({nm, ".bubbleFault"}, faultW, 0);
            end else begin
                done = 1;
                expFault = illegal ? 2'b11 : mis ? 2'b01 : toNow ? 2'b10 : 2'b00;
                check({nm, ".validW"},    validW, v);
                check({nm, ".RegWriteW"}, RegWriteW, v && rw && !(isMem && mw) && expFault == 2'b00);
                check({nm, ".faultW"},    faultW, expFault);
                if (v) begin
                    check({nm, ".ALUoutW"},   ALUoutW, addr);
                    check({nm, ".rdW"},       rdW, rd);
                    check({nm, ".MemtoRegW"}, MemtoRegW, m2r);
                end
                if (v && !isMem)
                    check({nm, ".readDataNM"}, readDataW, 0);
                if (access && !mw && !toNow)
                    check({nm, ".readDataW"}, readDataW, expRead);
            end
            cyc++;
        end
        bus.dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        validM = 1'b1; strCtrlM = 3'b010; RegWriteM = 1'b1; MemWriteM = 1'b1; MemtoRegM = 1'b0;
        ALUoutM = 32'h100; r2M = 32'h12345678; rdM = 5'd3;
        #2 rst = 1'b1;
        #1;
        check("rst.req",    bus.dmem_req, 0);
        check("rst.stall",  stallM, 0);
        check("rst.we",     bus.dmem_we, 0);
        check("rst.be",     bus.dmem_be, 0);
        check("rst.validW", validW, 0);
        check("rst.RegW",   RegWriteW, 0);
        check("rst.fault",  faultW, 0);
        check("rst.rdata",  readDataW, 0);
        check("rst.rdW",    rdW, 0);
        repeat (2) @(posedge clk);
        #1 check("rstHold.req", bus.dmem_req, 0);
        validM = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        runOp("SW",    1, 3'b010, 0, 1, 0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 32'h0);
        runOp("LB",    1, 3'b000, 1, 0, 1, 32'h103, 32'h0, 5'd5, 0, 32'h80FF7F01);
        runOp("LBU",   1, 3'b100, 1, 0, 1, 32'h103, 32'h0, 5'd6, 0, 32'h80FF7F01);
        runOp("LHwait",1, 3'b001, 1, 0, 1, 32'h102, 32'h0, 5'd7, 3, 32'h9ABC1234);
        runOp("LWmis", 1, 3'b010, 1, 0, 1, 32'h101, 32'h0, 5'd8, 0, 32'h0);
        runOp("SBto",  1, 3'b000, 0, 1, 0, 32'h100, 32'h000000A5, 5'd0, -1, 32'h0);
        runOp("SH",    1, 3'b001, 1, 1, 0, 32'h0FE, 32'h0000BEEF, 5'd9, 1, 32'h0);
        runOp("LDill", 1, 3'b011, 1, 0, 1, 32'h200, 32'h0, 5'd10, 0, 32'h0);
        runOp("SBUill",1, 3'b100, 0, 1, 0, 32'h200, 32'h0, 5'd0, 0, 32'h0);
        runOp("ALU",   1, 3'b000, 1, 0, 0, 32'hCAFE0001, 32'h0, 5'd11, 0, 32'h0);
        runOp("bubble",0, 3'b010, 1, 0, 1, 32'h300, 32'h0, 5'd12, 0, 32'h0);

        // Reset while waiting on the bus.
        validM = 1'b1; strCtrlM = 3'b010; RegWriteM = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b1;
        ALUoutM = 32'h200; rdM = 5'd4; bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("rstWait.reqBefore", bus.dmem_req, 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstWait.req",    bus.dmem_req, 0);
        check("rstWait.stall",  stallM, 0);
        check("rstWait.validW", validW, 0);
        validM = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        runOp("postRst", 1, 3'b000, 1, 0, 0, 32'h12345678, 32'h0, 5'd13, 0, 32'h0);

        for (int i = 0; i < 80; i++) begin
            int kind, dly;
            logic mw, m2r;
            kind = $urandom_range(0, 2);
            mw   = (kind == 2);
            m2r  = (kind == 1);
            dly  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
            runOp("rand", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), mw, m2r, $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), dly, $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, 16, maximum cycles waited for dmem_ack before a bus error is declared.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 validM  input  1  EX/MEM register holds a live instruction.
REQ-005 strCtrlM  input  3  funct3 of the load or store: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 RegWriteM, MemWriteM, MemtoRegM  input  1 each  control from execute; MemtoRegM=1 marks a load.
REQ-007 ALUoutM  input  32  effective address, or the ALU result for non-memory instructions.
REQ-008 r2M  input  32  store data; rdM  input  5  destination register.
REQ-009 dmem_req, dmem_we  output  1 each  bus request and write strobe.
REQ-010 dmem_addr  output  32  word-aligned address, {ALUoutM[31:2],2'b00}.
REQ-011 dmem_be  output  4  byte enables; dmem_wdata  output  32  lane-replicated store data.
REQ-012 dmem_ack  input  1  access complete; dmem_rdata  input  32  read word, valid while dmem_ack=1.
REQ-013 stallM  output  1  holds the upstream stages and the EX/MEM register.
REQ-014 validW, RegWriteW, MemtoRegW  output  1 each  MEM/WB register fields.
REQ-015 ALUoutW, readDataW  output  32 each; rdW  output  5.
REQ-016 faultW  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3.

Function
REQ-017 A memory op is validM & (MemWriteM | MemtoRegM).
REQ-018 FSM states: IDLE and WAIT.
REQ-019 IDLE, aligned legal memory op: assert dmem_req combinationally in the same cycle; if dmem_ack=1, complete with zero wait and stallM=0; otherwise stallM=1 and go to WAIT.
REQ-020 WAIT: keep dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stable and assert stallM.
REQ-021 WAIT, on dmem_ack: complete, deassert stallM, and return to IDLE.
REQ-022 WAIT, timeout: a cycle counter starts at 0 on entry and increments each cycle in WAIT; when it reaches TIMEOUT-1 without dmem_ack, drop dmem_req, complete with faultW=10, and return to IDLE.
REQ-023 Misaligned accesses (H/HU with addr[0]=1; W with addr[1:0]!=0) complete in one cycle without dmem_req, with faultW=01.
REQ-024 Illegal funct3 (load 011/110/111; store other than 000/001/010) completes in one cycle without dmem_req, with faultW=11.
REQ-025 Any fault forces RegWriteW=0 and validW=1.
REQ-026 Store byte enables: SB sets 0001<<addr[1:0]; SH sets 0011<<addr[1:0]; SW sets 1111.
REQ-027 Store data: wdata replicates the byte or halfword across all lanes.
REQ-028 Load data: select the byte or halfword by addr[1:0]; B/H sign-extend to 32 bits; BU/HU zero-extend.
REQ-029 Non-memory instructions pass through in one cycle: readDataW=0, ALUoutM->ALUoutW.
REQ-030 MEM/WB register load: on completion, or whenever no memory op is present, capture the M-stage fields.
REQ-031 MEM/WB bubble: while stallM=1, load a bubble (validW=0, RegWriteW=0, faultW=00).
REQ-032 Completed stores write validW=1 and RegWriteW=0.
REQ-033 validM=0 produces validW=0 and RegWriteW=0 on the next edge.

Reset
REQ-034 rst=1 sets the FSM to IDLE and clears the counter and every MEM/WB output to 0, independent of clk.
REQ-035 rst asserted during WAIT abandons the access and drops dmem_req immediately.
REQ-036 dmem_req, stallM, dmem_we and dmem_be shall be 0 while rst=1.

Structure
REQ-037 A shared package holds the funct3 encodings, the fault codes, the FSM state type and the TIMEOUT default.
REQ-038 One combinational sub-module, mem_load_ext, performs the load byte/half selection and extension.

Verification
REQ-039 SW r2M=0xDEADBEEF to ALUoutM=0x100, ack same cycle -> be=1111, addr=0x100, wdata=0xDEADBEEF, no stall, RegWriteW=0.
REQ-040 LB at 0x103 with rdata=0x80FF7F01 -> readDataW=0xFFFFFF80; LBU -> 0x00000080.
REQ-041 LH at 0x102, ack after 3 wait cycles -> stallM=1 for 3 cycles, 3 bubbles written, then readDataW set by rdata[31:16] sign-extended.
REQ-042 LW at 0x101 -> no dmem_req, faultW=01, RegWriteW=0.
REQ-043 SB at 0x100, never acked -> dmem_req held 16 cycles, then faultW=10 and stallM released.
REQ-044 rst pulsed during WAIT -> dmem_req=0 and validW=0 immediately, then IDLE.
